// File: rtl/axi4lite_to_fifo_channels.sv
// AXI4-Lite slave fanning out to NUM_CH tx/rx FIFO pairs. Each channel owns an
// 8-byte window at BASE_ADDR: DATA at +0, STATUS (flags and counters) at +4.
module axi4lite_to_fifo_channels #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_CH     = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0500,
    parameter int                    RD_LATENCY = 2
) (
    input  logic                         clk_main_a0,
    input  logic                         rst_main_sync,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic                         wvalid,
    output logic                         wready,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    output logic                         bvalid,
    input  logic                         bready,
    output logic [1:0]                   bresp,
    input  logic                         arvalid,
    output logic                         arready,
    input  logic [ADDR_WIDTH-1:0]        araddr,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [1:0]                   rresp,
    output logic [NUM_CH-1:0]            tx_wr,
    output logic [NUM_CH*DATA_WIDTH-1:0] tx_din,
    input  logic [NUM_CH-1:0]            tx_full,
    output logic [NUM_CH-1:0]            rx_rd,
    input  logic [NUM_CH*DATA_WIDTH-1:0] rx_dout,
    input  logic [NUM_CH-1:0]            rx_empty
);

    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic            mapped;
        logic            status;
        logic [CH_W-1:0] ch;
    } dec_t;

    typedef enum logic [1:0] {R_IDLE, R_POP, R_WAIT, R_RESP} rd_state_t;

    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        dec_t                  d;
        off      = addr - BASE_ADDR;
        d.mapped = (addr >= BASE_ADDR) && ((off >> 3) < ADDR_WIDTH'(NUM_CH))
                   && (off[1:0] == 2'b00);
        d.status = off[2];
        d.ch     = off[CH_W+2:3];
        return d;
    endfunction

    // Handshake readies stay low through reset and rise one cycle after release.
    logic                    ready_en_reg;
    logic                    aw_held_reg;
    logic [ADDR_WIDTH-1:0]   aw_addr_reg;
    logic                    w_held_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [STRB_W-1:0]       wstrb_reg;
    logic                    bvalid_reg;
    logic [1:0]              bresp_reg;
    dec_t                    aw_dec;
    logic                    commit;
    logic                    commit_ok;
    logic [1:0]              commit_resp;

    rd_state_t               rd_state_reg;
    rd_state_t               rd_state_next;
    logic [CH_W-1:0]         rd_ch_reg;
    logic [1:0]              wait_cnt_reg;
    logic                    rvalid_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic [1:0]              rresp_reg;
    dec_t                    ar_dec;
    logic                    ar_hs;
    logic                    ar_pop;
    logic                    wait_done;
    logic                    rsp_hs;
    logic [DATA_WIDTH-1:0]   ar_status;
    logic [NUM_CH*8-1:0]     push_cnt_flat;
    logic [NUM_CH*8-1:0]     pop_cnt_flat;

    assign awready = ready_en_reg && !aw_held_reg;
    assign wready  = ready_en_reg && !w_held_reg;
    assign bvalid  = bvalid_reg;
    assign bresp   = bresp_reg;
    assign rvalid  = rvalid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;

    // ---------------- write path ----------------
    assign aw_dec    = decode(aw_addr_reg);
    assign commit    = aw_held_reg && w_held_reg && !bvalid_reg;
    assign commit_ok = commit && aw_dec.mapped && !aw_dec.status
                       && (&wstrb_reg) && !tx_full[aw_dec.ch];

    always_comb begin
        commit_resp = RESP_SLVERR;
        if (!aw_dec.mapped) begin
            commit_resp = RESP_DECERR;
        end else if (commit_ok) begin
            commit_resp = RESP_OKAY;
        end
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            ready_en_reg <= 1'b0;
            aw_held_reg  <= 1'b0;
            aw_addr_reg  <= '0;
            w_held_reg   <= 1'b0;
            wdata_reg    <= '0;
            wstrb_reg    <= '0;
            bvalid_reg   <= 1'b0;
            bresp_reg    <= 2'b00;
        end else begin
            ready_en_reg <= 1'b1;
            if (awvalid && awready) begin
                aw_held_reg <= 1'b1;
                aw_addr_reg <= awaddr;
            end
            if (wvalid && wready) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= wdata;
                wstrb_reg  <= wstrb;
            end
            // Failed pushes are dropped with SLVERR so the bus never stalls.
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= commit_resp;
            end else if (bvalid_reg && bready) begin
                bvalid_reg <= 1'b0;
                bresp_reg  <= 2'b00;
            end
        end
    end

    // ---------------- read path ----------------
    assign ar_dec    = decode(araddr);
    assign ar_hs     = arvalid && arready;
    assign ar_pop    = ar_dec.mapped && !ar_dec.status && !rx_empty[ar_dec.ch];
    assign wait_done = (rd_state_reg == R_WAIT) && (wait_cnt_reg == 2'(RD_LATENCY - 1));
    assign rsp_hs    = rvalid_reg && rready;

    always_comb begin
        ar_status        = '0;
        ar_status[0]     = rx_empty[ar_dec.ch];
        ar_status[1]     = tx_full[ar_dec.ch];
        ar_status[23:16] = push_cnt_flat[ar_dec.ch*8 +: 8];
        ar_status[31:24] = pop_cnt_flat[ar_dec.ch*8 +: 8];
    end

    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            rd_state_reg <= R_IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
        end
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE: if (ar_hs) rd_state_next = ar_pop ? R_POP : R_RESP;
            R_POP:  rd_state_next = R_WAIT;
            R_WAIT: if (wait_done) rd_state_next = R_RESP;
            R_RESP: if (rsp_hs) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = ready_en_reg && (rd_state_reg == R_IDLE);
        rx_rd   = '0;
        if (rd_state_reg == R_POP) begin
            rx_rd[rd_ch_reg] = 1'b1;
        end
    end

    // Immediate responses load rdata at the AR edge and raise rvalid one edge later.
    always_ff @(posedge clk_main_a0) begin
        if (rst_main_sync) begin
            rd_ch_reg    <= '0;
            wait_cnt_reg <= 2'd0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= 2'b00;
        end else begin
            if (ar_hs) begin
                rd_ch_reg <= ar_dec.ch;
                if (!ar_dec.mapped) begin
                    rdata_reg <= '0;
                    rresp_reg <= RESP_DECERR;
                end else if (ar_dec.status) begin
                    rdata_reg <= ar_status;
                    rresp_reg <= RESP_OKAY;
                end else if (!ar_pop) begin
                    rdata_reg <= '0;
                    rresp_reg <= RESP_SLVERR;
                end
            end
            if (rd_state_reg == R_POP) begin
                wait_cnt_reg <= 2'd0;
            end else if (rd_state_reg == R_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 2'd1;
            end
            if (wait_done) begin
                rdata_reg  <= rx_dout[rd_ch_reg*DATA_WIDTH +: DATA_WIDTH];
                rresp_reg  <= RESP_OKAY;
                rvalid_reg <= 1'b1;
            end else if ((rd_state_reg == R_RESP) && !rvalid_reg) begin
                rvalid_reg <= 1'b1;
            end else if (rsp_hs) begin
                rvalid_reg <= 1'b0;
                rdata_reg  <= '0;
                rresp_reg  <= 2'b00;
            end
        end
    end

    // ---------------- per-channel strobes and counters ----------------
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic                  push_hit;
        logic                  pop_hit;
        logic [7:0]            push_cnt_reg;
        logic [7:0]            pop_cnt_reg;
        logic                  tx_wr_reg;
        logic [DATA_WIDTH-1:0] tx_din_reg;

        assign push_hit = commit_ok && (aw_dec.ch == CH_W'(gi));
        assign pop_hit  = wait_done && (rd_ch_reg == CH_W'(gi));

        always_ff @(posedge clk_main_a0) begin
            if (rst_main_sync) begin
                push_cnt_reg <= 8'd0;
                pop_cnt_reg  <= 8'd0;
                tx_wr_reg    <= 1'b0;
                tx_din_reg   <= '0;
            end else begin
                if (push_hit) push_cnt_reg <= push_cnt_reg + 8'd1;
                if (pop_hit)  pop_cnt_reg  <= pop_cnt_reg + 8'd1;
                tx_wr_reg  <= push_hit;
                tx_din_reg <= push_hit ? wdata_reg : '0;
            end
        end

        assign tx_wr[gi]                            = tx_wr_reg;
        assign tx_din[gi*DATA_WIDTH +: DATA_WIDTH]  = tx_din_reg;
        assign push_cnt_flat[gi*8 +: 8]             = push_cnt_reg;
        assign pop_cnt_flat[gi*8 +: 8]              = pop_cnt_reg;
    end

endmodule

// File: tb/tb_axi4lite_to_fifo_channels.sv
// Directed bench for axi4lite_to_fifo_channels: a register-map model predicts
// responses, pushes and pops; a negedge monitor compares them against the DUT.
module tb_axi4lite_to_fifo_channels;

    localparam int          NCH  = 4;
    localparam logic [31:0] BASE = 32'h0000_0500;

    logic         clk;
    logic         rst;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  awaddr, araddr, wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [3:0]   tx_wr, tx_full, rx_rd, rx_empty;
    logic [127:0] tx_din, rx_dout;

    axi4lite_to_fifo_channels dut (
        .clk_main_a0  (clk),
        .rst_main_sync(rst),
        .awvalid      (awvalid),
        .awready      (awready),
        .awaddr       (awaddr),
        .wvalid       (wvalid),
        .wready       (wready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .bvalid       (bvalid),
        .bready       (bready),
        .bresp        (bresp),
        .arvalid      (arvalid),
        .arready      (arready),
        .araddr       (araddr),
        .rvalid       (rvalid),
        .rready       (rready),
        .rdata        (rdata),
        .rresp        (rresp),
        .tx_wr        (tx_wr),
        .tx_din       (tx_din),
        .tx_full      (tx_full),
        .rx_rd        (rx_rd),
        .rx_dout      (rx_dout),
        .rx_empty     (rx_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // Register-map model state and expectation queues.
    logic [7:0]  push_cnt [NCH];
    logic [7:0]  pop_cnt  [NCH];
    logic [1:0]  exp_b_q[$];
    logic [33:0] exp_r_q[$];
    int          exp_tx_ch_q[$];
    logic [31:0] exp_tx_d_q[$];
    int          exp_pop_q[$];
    logic [127:0] cmp_vec;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] off;
        logic [1:0]  resp;
        int          c;
        off = addr - BASE;
        if (addr < BASE || off / 32'd8 >= 32'(NCH) || off % 32'd4 != 32'd0) begin
            resp = 2'b11;
        end else begin
            c = int'(off / 32'd8);
            if (off % 32'd8 >= 32'd4 || strb != 4'hF || tx_full[c]) begin
                resp = 2'b10;
            end else begin
                resp = 2'b00;
                push_cnt[c] = push_cnt[c] + 8'd1;
                exp_tx_ch_q.push_back(c);
                exp_tx_d_q.push_back(data);
            end
        end
        exp_b_q.push_back(resp);
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [33:0] e);
        logic [31:0] off;
        int          c;
        off = addr - BASE;
        if (addr < BASE || off / 32'd8 >= 32'(NCH) || off % 32'd4 != 32'd0) begin
            e = {2'b11, 32'h0};
        end else begin
            c = int'(off / 32'd8);
            if (off % 32'd8 >= 32'd4) begin
                e = {2'b00, pop_cnt[c], push_cnt[c], 14'h0, tx_full[c], rx_empty[c]};
            end else if (rx_empty[c]) begin
                e = {2'b10, 32'h0};
            end else begin
                e = {2'b00, rx_dout[c*32 +: 32]};
                exp_pop_q.push_back(c);
                pop_cnt[c] = pop_cnt[c] + 8'd1;
            end
        end
        exp_r_q.push_back(e);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int gap, output logic [1:0] got_resp, output int lat,
                             output logic [3:0] wr_at_b, output logic [127:0] din_at_b);
        int n;
        bit aw_done, w_done, hs_aw, hs_w;
        model_write(addr, data, strb);
        aw_done = 1'b0;
        w_done  = 1'b0;
        n       = 0;
        awaddr  = addr;
        awvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            if (n == gap) begin
                wvalid = 1'b1;
                wdata  = data;
                wstrb  = strb;
            end
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (hs_w)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            n++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("aw_w_handshake", 128'(aw_done && w_done), 128'(1));
        bready = 1'b1;
        lat    = 0;
        while (!bvalid && lat < 50) begin
            tick();
            lat++;
        end
        chk("bvalid_seen", 128'(bvalid), 128'(1));
        got_resp = bresp;
        wr_at_b  = tx_wr;
        din_at_b = tx_din;
        tick();
        bready = 1'b0;
        $display("write addr=%08h data=%08h strb=%h bresp=%0d", addr, data, strb, got_resp);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int hold, output logic [31:0] got_data,
                            output logic [1:0] got_resp, output int lat);
        logic [33:0] e;
        int          n;
        model_read(addr, e);
        araddr  = addr;
        arvalid = 1'b1;
        n       = 0;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        chk("arready_seen", 128'(arready), 128'(1));
        tick();
        arvalid = 1'b0;
        lat     = 0;
        while (!rvalid && lat < 50) begin
            tick();
            lat++;
        end
        chk("rvalid_seen", 128'(rvalid), 128'(1));
        for (int i = 0; i < hold; i++) begin
            chk("r_hold_stable", 128'({rresp, rdata}), 128'(e));
            tick();
        end
        got_data = rdata;
        got_resp = rresp;
        rready   = 1'b1;
        tick();
        rready   = 1'b0;
        $display("read  addr=%08h rdata=%08h rresp=%0d latency=%0d", addr, got_data, got_resp, lat);
    endtask

    // Monitor: every non-reset cycle, check strobes and response handshakes.
    always @(negedge clk) begin
        int c;
        if (mon_en && !rst) begin
            if (tx_wr != 4'b0) begin
                if (exp_tx_ch_q.size() == 0) begin
                    chk("tx_wr_spurious", 128'(tx_wr), 128'(0));
                end else begin
                    c       = exp_tx_ch_q.pop_front();
                    cmp_vec = '0;
                    cmp_vec[c*32 +: 32] = exp_tx_d_q.pop_front();
                    chk("tx_wr", 128'(tx_wr), 128'(4'b1 << c));
                    chk("tx_din", tx_din, cmp_vec);
                end
            end else begin
                chk("tx_din_idle", tx_din, 128'(0));
            end
            if (rx_rd != 4'b0) begin
                if (exp_pop_q.size() == 0) begin
                    chk("rx_rd_spurious", 128'(rx_rd), 128'(0));
                end else begin
                    c = exp_pop_q.pop_front();
                    chk("rx_rd", 128'(rx_rd), 128'(4'b1 << c));
                end
            end
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) chk("b_spurious", 128'(bvalid), 128'(0));
                else chk("bresp", 128'(bresp), 128'(exp_b_q.pop_front()));
            end
            if (rvalid && rready) begin
                if (exp_r_q.size() == 0) chk("r_spurious", 128'(rvalid), 128'(0));
                else chk("rresp_rdata", 128'({rresp, rdata}), 128'(exp_r_q.pop_front()));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1);
    end

    logic [31:0]  gd, gd2;
    logic [1:0]   gr, gr2;
    int           lat, lat2;
    logic [3:0]   wab;
    logic [127:0] dab;

    initial begin
        rst = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        tx_full = 4'b0; rx_empty = 4'b0; rx_dout = '0;
        for (int i = 0; i < NCH; i++) begin
            push_cnt[i] = 8'd0;
            pop_cnt[i]  = 8'd0;
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Reset in the middle of a DATA read (R_WAIT); the pop is lost.
        rx_dout[31:0] = 32'hAAAA_5555;
        araddr  = BASE;
        arvalid = 1'b1;
        exp_pop_q.push_back(0);
        tick();
        arvalid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ctrl_outputs", 128'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rx_rd, tx_wr}), 128'(0));
        chk("rst_rdata", 128'(rdata), 128'(0));
        chk("rst_tx_din", tx_din, 128'(0));
        rst = 1'b0;
        tick();
        chk("post_rst_readies", 128'({awready, wready, arready}), 128'(3'b111));
        axi_read(BASE + 32'h4, 0, gd, gr, lat);
        chk("ch0_status_after_rst", 128'(gd[31:16]), 128'(0));

        // ch3 DATA write, AW and W together: push and bvalid one edge later.
        axi_write(BASE + 32'h18, 32'hDEAD_BEEF, 4'hF, 0, gr, lat, wab, dab);
        chk("ch3_bresp", 128'(gr), 128'(2'b00));
        chk("ch3_b_latency", 128'(lat), 128'(1));
        chk("ch3_tx_wr", 128'(wab), 128'(4'b1000));
        chk("ch3_tx_din", 128'(dab[127:96]), 128'(32'hDEAD_BEEF));
        axi_read(BASE + 32'h1C, 0, gd, gr, lat);
        chk("ch3_push_cnt", 128'(gd[23:16]), 128'(8'd1));
        chk("status_latency", 128'(lat), 128'(1));

        // Error writes: full FIFO, partial strobe, STATUS target, unmapped.
        tx_full = 4'b0010;
        axi_write(BASE + 32'h08, 32'h1111_1111, 4'hF, 0, gr, lat, wab, dab);
        chk("ch1_full_bresp", 128'(gr), 128'(2'b10));
        chk("ch1_full_no_push", 128'(wab), 128'(0));
        tx_full = 4'b0000;
        axi_write(BASE + 32'h10, 32'h2222_2222, 4'h7, 0, gr, lat, wab, dab);
        chk("partial_strb_bresp", 128'(gr), 128'(2'b10));
        axi_write(BASE + 32'h0C, 32'h3333_3333, 4'hF, 1, gr, lat, wab, dab);
        chk("status_write_bresp", 128'(gr), 128'(2'b10));
        axi_write(BASE + 32'h40, 32'h4444_4444, 4'hF, 0, gr, lat, wab, dab);
        chk("unmapped_bresp", 128'(gr), 128'(2'b11));

        // ch2 DATA read with rready held low for 5 cycles.
        rx_dout[95:64] = 32'h1234_5678;
        axi_read(BASE + 32'h10, 5, gd, gr, lat);
        chk("ch2_rdata", 128'(gd), 128'(32'h1234_5678));
        chk("ch2_rresp", 128'(gr), 128'(2'b00));
        chk("ch2_latency", 128'(lat), 128'(3));
        axi_read(BASE - 32'h4, 0, gd, gr, lat);
        chk("below_base_rresp", 128'(gr), 128'(2'b11));
        axi_read(BASE + 32'h2, 0, gd, gr, lat);
        chk("misaligned_rresp", 128'(gr), 128'(2'b11));

        // Empty ch0 DATA read, then 256 pops to wrap the pop counter.
        rx_empty = 4'b0001;
        axi_read(BASE, 0, gd, gr, lat);
        chk("ch0_empty_rdata", 128'(gd), 128'(0));
        chk("ch0_empty_rresp", 128'(gr), 128'(2'b10));
        chk("ch0_empty_latency", 128'(lat), 128'(1));
        rx_empty = 4'b0000;
        for (int i = 0; i < 255; i++) begin
            rx_dout[31:0] = 32'h0100_0000 + 32'(i);
            axi_read(BASE, 0, gd, gr, lat);
        end
        axi_read(BASE + 32'h4, 0, gd, gr, lat);
        chk("ch0_pop_cnt_255", 128'(gd[31:24]), 128'(8'hFF));
        axi_read(BASE, 0, gd, gr, lat);
        axi_read(BASE + 32'h4, 0, gd, gr, lat);
        chk("ch0_pop_cnt_wrap", 128'(gd[31:24]), 128'(8'h00));

        // Concurrent write and read to ch0 DATA; W trails AW by 3 cycles.
        rx_dout[31:0] = 32'hCAFE_F00D;
        fork
            axi_write(BASE, 32'h5A5A_0001, 4'hF, 3, gr, lat, wab, dab);
            axi_read(BASE, 0, gd2, gr2, lat2);
        join
        chk("conc_bresp", 128'(gr), 128'(2'b00));
        chk("conc_b_latency", 128'(lat), 128'(1));
        chk("conc_rdata", 128'(gd2), 128'(32'hCAFE_F00D));
        axi_read(BASE + 32'h4, 0, gd, gr, lat);
        chk("conc_ch0_status", 128'(gd), 128'(32'h0101_0000));

        repeat (3) tick();
        chk("leftover_b", 128'(exp_b_q.size()), 128'(0));
        chk("leftover_r", 128'(exp_r_q.size()), 128'(0));
        chk("leftover_tx", 128'(exp_tx_ch_q.size()), 128'(0));
        chk("leftover_pop", 128'(exp_pop_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
